// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the data cache controller.
//   state_e      : controller FSM state encoding
//   DEF_*        : default geometry (16 lines x 4 words, 32-bit byte address)
//   sat_inc()    : saturating 32-bit increment used by the performance counters
package dcache_pkg;

  localparam int unsigned DEF_LINES  = 16;
  localparam int unsigned DEF_WORDS  = 4;
  localparam int unsigned DEF_ADDR_W = 32;

  // Address field widths for the default geometry; modules recompute these
  // from their own parameters so overrides stay consistent.
  localparam int unsigned DEF_IDX_W = $clog2(DEF_LINES);
  localparam int unsigned DEF_OFF_W = $clog2(DEF_WORDS);
  localparam int unsigned DEF_TAG_W = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2,
    WRITE     = 2'd3
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: storage for the direct-mapped data cache.
//   clk, rst            : clock, synchronous active-high reset (clears valid bits only)
//   i_rd_idx/i_rd_off   : combinational read address (line index, word offset)
//   o_rd_tag/o_rd_valid : tag and valid bit of the addressed line
//   o_rd_data           : addressed data word
//   i_tv_*              : tag/valid write port (one line per cycle)
//   i_d_*               : data write port (one word per cycle)
module dcache_array #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TAG_W = 26,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned OFF_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFF_W-1:0] i_rd_off,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic             o_rd_valid,
  output logic [31:0]      o_rd_data,
  input  logic             i_tv_we,
  input  logic [IDX_W-1:0] i_tv_idx,
  input  logic [TAG_W-1:0] i_tv_tag,
  input  logic             i_tv_valid,
  input  logic             i_d_we,
  input  logic [IDX_W-1:0] i_d_idx,
  input  logic [OFF_W-1:0] i_d_off,
  input  logic [31:0]      i_d_data
);

  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES*WORDS];
  logic [LINES-1:0] r_valid;

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_tv_we) begin
      r_valid[i_tv_idx] <= i_tv_valid;
    end
  end

  // Tag and data RAMs are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (i_tv_we) begin
      r_tag[i_tv_idx] <= i_tv_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (i_d_we) begin
      r_data[{i_d_idx, i_d_off}] <= i_d_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst              : clock, synchronous active-high reset
//   cpu_req/cpu_we        : core load/store request, 1 = store
//   cpu_addr/cpu_wdata    : byte address ([1:0] ignored), store data
//   cpu_rdata             : load data, valid when cpu_req & !cpu_we & !cpu_stall
//   cpu_stall             : combinational pipeline freeze
//   mem_req/mem_we        : word request / write enable towards data_mem
//   mem_addr/mem_wdata    : word-aligned address and write data
//   mem_rdata/mem_ready   : read data and one-cycle completion strobe
//   hit_cnt/miss_cnt      : saturating load hit / load miss counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES  = DEF_LINES,
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  state_e            r_state;
  logic [OFF_W-1:0]  r_cnt;
  logic [WA_W-1:0]   r_waddr;
  logic [31:0]       r_wdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [WA_W-1:0]   w_sel;
  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [TAG_W-1:0]  w_rd_tag;
  logic              w_rd_valid;
  logic [31:0]       w_rd_data;
  logic              w_hit;
  logic              w_load_hit;

  logic              w_tv_we;
  logic              w_tv_valid;
  logic              w_d_we;
  logic [OFF_W-1:0]  w_d_off;
  logic [31:0]       w_d_data;

  // In IDLE the lookup follows the live core address; once a transaction is
  // accepted it follows the latched word address, so a refill still finishes
  // into the right line if the core drops cpu_req.
  assign w_sel = (r_state == IDLE) ? cpu_addr[ADDR_W-1:2] : r_waddr;
  assign w_off = w_sel[OFF_W-1:0];
  assign w_idx = w_sel[IDX_W+OFF_W-1:OFF_W];
  assign w_tag = w_sel[WA_W-1:IDX_W+OFF_W];

  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
  assign w_load_hit = cpu_req && !cpu_we && (r_state == IDLE) && w_hit;

  assign cpu_rdata = w_load_hit ? w_rd_data : '0;
  assign cpu_stall = cpu_req
                   && !((r_state == IDLE) && w_hit && !cpu_we)
                   && !((r_state == WRITE) && mem_ready);

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_wdata;
  assign mem_addr  = (r_state == WRITE) ? {r_waddr, 2'b00}
                                        : {r_waddr[WA_W-1:OFF_W], r_cnt, 2'b00};
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // A load miss invalidates the victim line up front so a refill aborted by
  // reset (or any partial fill) can never be mistaken for resident data.
  always_comb begin
    w_tv_we    = 1'b0;
    w_tv_valid = 1'b0;
    if ((r_state == IDLE) && cpu_req && !cpu_we && !w_hit) begin
      w_tv_we = 1'b1;
    end else if (r_state == FILL_DONE) begin
      w_tv_we    = 1'b1;
      w_tv_valid = 1'b1;
    end
  end

  always_comb begin
    w_d_we   = 1'b0;
    w_d_off  = w_off;
    w_d_data = r_wdata;
    if ((r_state == REFILL) && mem_ready) begin
      w_d_we   = 1'b1;
      w_d_off  = r_cnt;
      w_d_data = mem_rdata;
    end else if ((r_state == WRITE) && mem_ready && w_hit) begin
      w_d_we = 1'b1;
    end
  end

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx),
    .i_rd_off   (w_off),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_rd_data),
    .i_tv_we    (w_tv_we),
    .i_tv_idx   (w_idx),
    .i_tv_tag   (w_tag),
    .i_tv_valid (w_tv_valid),
    .i_d_we     (w_d_we),
    .i_d_idx    (w_idx),
    .i_d_off    (w_d_off),
    .i_d_data   (w_d_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              r_state   <= WRITE;
              r_waddr   <= cpu_addr[ADDR_W-1:2];
              r_wdata   <= cpu_wdata;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b1;
            end else if (w_hit) begin
              r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
              r_state    <= REFILL;
              r_waddr    <= cpu_addr[ADDR_W-1:2];
              r_cnt      <= '0;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_miss_cnt <= sat_inc(r_miss_cnt);
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            r_cnt <= r_cnt + OFF_W'(1);
            if (r_cnt == LAST_OFF) begin
              r_state   <= FILL_DONE;
              r_mem_req <= 1'b0;
            end
          end
        end
        FILL_DONE: begin
          r_state <= IDLE;
        end
        WRITE: begin
          if (mem_ready) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
      endcase
    end
  end

  // The core must hold its address while stalled.
  property p_hold_addr;
    @(posedge clk) disable iff (rst)
      (cpu_req && cpu_stall) |=> (!cpu_req || (cpu_addr == $past(cpu_addr)));
  endproperty
  a_hold_addr: assert property (p_hold_addr);

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [31:0] mem_w [1024];
  int unsigned strobe_cnt;
  int unsigned wr_cnt;
  int unsigned req_cycles;
  logic [31:0] last_wr_addr;

  dcache_ctrl #(
    .LINES  (16),
    .WORDS  (4),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem model: answers each request after a random 0-5 cycle delay.
  initial begin
    int unsigned dly;
    mem_ready = 1'b0;
    mem_rdata = '0;
    dly = $urandom_range(0, 5);
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        dly = $urandom_range(0, 5);
      end else if (mem_req) begin
        if (dly == 0) begin
          mem_ready = 1'b1;
          if (mem_we) mem_w[mem_addr[11:2]] = mem_wdata;
          else        mem_rdata = mem_w[mem_addr[11:2]];
        end else begin
          dly--;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mem_req) req_cycles++;
    if (mem_req && mem_ready) begin
      strobe_cnt++;
      if (mem_we) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
      end
    end
  end

  task automatic wait_done(output logic [31:0] rd);
    int unsigned n;
    logic st;
    n = 0;
    rd = '0;
    forever begin
      #4;
      st = cpu_stall;
      rd = cpu_rdata;
      @(posedge clk);
      if (!st) break;
      n++;
      if (n > 1000) begin
        total_cnt++;
        $display("FAIL stall_timeout: addr %h still stalled after %0d cycles, required release", cpu_addr, n);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    wait_done(rd);
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (hit_cnt !== 32'd0) $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); else pass_cnt++;
    total_cnt++;
    if (miss_cnt !== 32'd0) $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); else pass_cnt++;
    total_cnt++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_req: got req=%b we=%b expected 0 0", mem_req, mem_we); else pass_cnt++;
    total_cnt++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'd0) $display("FAIL reset_idle_outputs: got stall=%b rdata=%h expected 0 0", cpu_stall, cpu_rdata); else pass_cnt++;
  endtask

  task automatic test_load_miss;
    logic [31:0] rd;
    int unsigned s0;
    s0 = strobe_cnt;
    do_access(1'b0, 32'h4, '0, rd);
    total_cnt++;
    if (rd !== 32'd1) $display("FAIL miss_rdata: got %h expected 00000001", rd); else pass_cnt++;
    total_cnt++;
    if (strobe_cnt - s0 !== 4) $display("FAIL miss_strobes: got %0d expected 4", strobe_cnt - s0); else pass_cnt++;
    total_cnt++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd1) $display("FAIL miss_counters: got miss=%0d hit=%0d expected 1 1", miss_cnt, hit_cnt); else pass_cnt++;
  endtask

  task automatic test_line_hits;
    logic [31:0] rd4, rd0;
    int unsigned r0;
    r0 = req_cycles;
    do_access(1'b0, 32'h4, '0, rd4);
    do_access(1'b0, 32'h0, '0, rd0);
    total_cnt++;
    if (rd4 !== 32'd1 || rd0 !== 32'd0) $display("FAIL hit_rdata: got %h %h expected 00000001 00000000", rd4, rd0); else pass_cnt++;
    total_cnt++;
    if (req_cycles - r0 !== 0) $display("FAIL hit_no_mem: got %0d mem_req cycles expected 0", req_cycles - r0); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 32'd3) $display("FAIL hit_cnt_after_hits: got %0d expected 3", hit_cnt); else pass_cnt++;
  endtask

  task automatic test_store_hit;
    logic [31:0] rd;
    int unsigned w0, r0;
    w0 = wr_cnt;
    do_access(1'b1, 32'h0, 32'd7, rd);
    total_cnt++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 32'h0) $display("FAIL store_hit_write: got %0d writes last addr %h expected 1 at 00000000", wr_cnt - w0, last_wr_addr); else pass_cnt++;
    total_cnt++;
    if (mem_w[0] !== 32'd7) $display("FAIL store_hit_mem: got %h expected 00000007", mem_w[0]); else pass_cnt++;
    r0 = req_cycles;
    do_access(1'b0, 32'h0, '0, rd);
    total_cnt++;
    if (rd !== 32'd7 || req_cycles - r0 !== 0) $display("FAIL store_hit_reload: got %h with %0d mem cycles expected 00000007 with 0", rd, req_cycles - r0); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1) $display("FAIL store_hit_counters: got hit=%0d miss=%0d expected 4 1", hit_cnt, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_store_miss;
    logic [31:0] rd;
    int unsigned w0, r0;
    w0 = wr_cnt;
    do_access(1'b1, 32'h100, 32'h0000_ABCD, rd);
    total_cnt++;
    if (wr_cnt - w0 !== 1 || mem_w[64] !== 32'h0000_ABCD) $display("FAIL store_miss_write: got %0d writes mem %h expected 1 0000abcd", wr_cnt - w0, mem_w[64]); else pass_cnt++;
    r0 = req_cycles;
    do_access(1'b0, 32'h0, '0, rd);
    total_cnt++;
    if (rd !== 32'd7 || req_cycles - r0 !== 0) $display("FAIL store_miss_line0: got %h with %0d mem cycles expected 00000007 with 0", rd, req_cycles - r0); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 32'd5 || miss_cnt !== 32'd1) $display("FAIL store_miss_counters: got hit=%0d miss=%0d expected 5 1", hit_cnt, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_evict;
    logic [31:0] ra, rb, rc;
    int unsigned m0, s0;
    m0 = miss_cnt;
    s0 = strobe_cnt;
    do_access(1'b0, 32'h40,  '0, ra);
    do_access(1'b0, 32'h440, '0, rb);
    do_access(1'b0, 32'h40,  '0, rc);
    total_cnt++;
    if (ra !== 32'hA000_0010 || rb !== 32'hA000_0110 || rc !== 32'hA000_0010)
      $display("FAIL evict_rdata: got %h %h %h expected a0000010 a0000110 a0000010", ra, rb, rc);
    else pass_cnt++;
    total_cnt++;
    if (miss_cnt - m0 !== 32'd3) $display("FAIL evict_misses: got %0d new misses expected 3", miss_cnt - m0); else pass_cnt++;
    total_cnt++;
    if (strobe_cnt - s0 !== 12) $display("FAIL evict_strobes: got %0d expected 12", strobe_cnt - s0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_refill;
    logic [31:0] rd;
    int unsigned s0, n;
    s0 = strobe_cnt;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h20;
    n = 0;
    while (strobe_cnt - s0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (strobe_cnt - s0 < 2) $display("FAIL rst_wait_strobes: got %0d strobes expected 2", strobe_cnt - s0); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL rst_abort_mem_req: got %b expected 0", mem_req); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    wait_done(rd);
    @(negedge clk);
    cpu_req = 1'b0;
    total_cnt++;
    if (strobe_cnt - s0 !== 4) $display("FAIL rst_full_refill: got %0d strobes expected 4", strobe_cnt - s0); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hA000_0008 || miss_cnt !== 32'd1 || hit_cnt !== 32'd1)
      $display("FAIL rst_retry: got rdata %h miss=%0d hit=%0d expected a0000008 1 1", rd, miss_cnt, hit_cnt);
    else pass_cnt++;
  endtask

  task automatic test_fibonacci;
    logic [31:0] a, b, rd;
    do_access(1'b1, 32'h800, 32'd0, rd);
    do_access(1'b1, 32'h804, 32'd1, rd);
    for (int unsigned i = 2; i <= 47; i++) begin
      do_access(1'b0, 32'h800 + 4 * (i - 2), '0, a);
      do_access(1'b0, 32'h800 + 4 * (i - 1), '0, b);
      do_access(1'b1, 32'h800 + 4 * i, a + b, rd);
    end
    do_access(1'b0, 32'h800 + 4 * 47, '0, rd);
    total_cnt++;
    if (rd !== 32'd2971215073) $display("FAIL fib_r2: got %0d expected 2971215073", rd); else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    strobe_cnt   = 0;
    wr_cnt       = 0;
    req_cycles   = 0;
    last_wr_addr = '0;
    rst          = 1'b1;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    for (int unsigned i = 0; i < 1024; i++) mem_w[i] = 32'hA000_0000 + i;
    mem_w[0] = 32'd0;
    mem_w[1] = 32'd1;

    test_reset();
    test_load_miss();
    test_line_hits();
    test_store_hit();
    test_store_miss();
    test_evict();
    test_reset_mid_refill();
    test_fibonacci();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
